phase_seq_ctrl: RTL and testbench

Parametrised multi-channel phase sequencer; successor to the fixed 3-input/14-flop controller benchmark.
- Latches per-channel service requests, grants channels round-robin, and steps each grant through GREEN -> YELLOW -> ALLRED.
- Each phase has a programmable dwell count; a synchronous clear input is kept alongside the asynchronous reset.
- Per-channel request-parity toggle flags and a cycle-done pulse are provided for downstream observation logic in the same netlist family.

---
 rtl/phase_seq_ctrl_if.sv | 38 +++
 rtl/phase_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_phase_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_seq_ctrl_if.sv
// phase_seq_ctrl_if
// Groups the request/clear inputs and the phase/status outputs of the
// phase sequencer into one bundle.
//   CLR    : synchronous clear, active high
//   REQ    : per-channel service requests
//   GRN    : one-hot GREEN indication for the served channel
//   YEL    : one-hot YELLOW indication for the served channel
//   ALLRED : high while the all-red clearance phase runs
//   BUSY   : high whenever the sequencer is not idle
//   CNT    : current phase counter
//   TOG    : per-channel request parity flags
//   DONE   : one-cycle pulse after a grant cycle has completed
// The slave modport is taken by the sequencer, the master modport by
// whatever drives the requests.
interface phase_seq_ctrl_if #(
  parameter int NCH = 4,
  parameter int CW  = 4
);
  logic           CLR;
  logic [NCH-1:0] REQ;
  logic [NCH-1:0] GRN;
  logic [NCH-1:0] YEL;
  logic           ALLRED;
  logic           BUSY;
  logic [CW-1:0]  CNT;
  logic [NCH-1:0] TOG;
  logic           DONE;

  modport slave (
    input  CLR, REQ,
    output GRN, YEL, ALLRED, BUSY, CNT, TOG, DONE
  );

  modport master (
    output CLR, REQ,
    input  GRN, YEL, ALLRED, BUSY, CNT, TOG, DONE
  );
endinterface

// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl
// Multi-channel phase sequencer. Requests are latched into a pending
// register, granted round-robin, and each grant is stepped through
// GREEN -> YELLOW -> ALLRED with a programmable dwell per phase.
// Ports:
//   CK  : clock, rising edge
//   RN  : asynchronous reset, active low
//   bus : phase_seq_ctrl_if slave (CLR/REQ in, phase and status out)
// All outputs are decoded from registers only.
module phase_seq_ctrl #(
  parameter int NCH       = 4,
  parameter int CW        = 4,
  parameter int GREEN_LEN = 8,
  parameter int YEL_LEN   = 3,
  parameter int RED_LEN   = 1
) (
  input logic               CK,
  input logic               RN,
  phase_seq_ctrl_if.slave   bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] G_LAST = CW'(GREEN_LEN - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(YEL_LEN - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RED_LEN - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_ALLRED
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [NCH-1:0] pend, tog, clr_mask;
  logic [PW-1:0]  ptr, cur, sel, idx;
  logic           found, grant, cycle_end, done;

  // Round-robin pick: walk the channels starting one past the last
  // grant, wrapping at NCH-1, and take the first pending one. The
  // explicit wrap keeps this correct for non power-of-two NCH.
  always_comb begin
    sel   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = (idx == P_LAST) ? '0 : idx + 1'b1;
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and counter logic. The counter restarts from zero on
  // every transition, so each phase lasts exactly its dwell length.
  // grant marks the edge at which a channel enters GREEN; only then is
  // its pending bit released.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    cycle_end = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (found) begin
          state_nxt = S_GREEN;
          grant     = 1'b1;
        end
      end
      S_GREEN: begin
        if (cnt == G_LAST) begin
          state_nxt = S_YELLOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_YELLOW: begin
        if (cnt == Y_LAST) begin
          state_nxt = S_ALLRED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_ALLRED: begin
        if (cnt == R_LAST) begin
          cycle_end = 1'b1;
          cnt_nxt   = '0;
          if (found) begin
            state_nxt = S_GREEN;
            grant     = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    clr_mask = grant ? (NCH'(1) << sel) : '0;
  end

  // State register. Clear behaves like reset at the edge it is seen,
  // aborting any phase in progress without a yellow/red tail.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
    end else if (bus.CLR) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers. A request arriving on the same edge its pending
  // bit is released keeps the bit set, so a continuously requesting
  // channel is queued again for its next turn. The parity flags follow
  // REQ regardless of the sequencer state.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt  <= '0;
      pend <= '0;
      tog  <= '0;
      ptr  <= P_LAST;
      cur  <= '0;
      done <= 1'b0;
    end else if (bus.CLR) begin
      cnt  <= '0;
      pend <= '0;
      tog  <= '0;
      ptr  <= P_LAST;
      cur  <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      pend <= (pend & ~clr_mask) | bus.REQ;
      tog  <= tog ^ bus.REQ;
      done <= cycle_end;
      if (grant) begin
        cur <= sel;
        ptr <= sel;
      end
    end
  end

  // Moore output decode.
  assign bus.GRN    = (state == S_GREEN)  ? (NCH'(1) << cur) : '0;
  assign bus.YEL    = (state == S_YELLOW) ? (NCH'(1) << cur) : '0;
  assign bus.ALLRED = (state == S_ALLRED);
  assign bus.BUSY   = (state != S_IDLE);
  assign bus.CNT    = cnt;
  assign bus.TOG    = tog;
  assign bus.DONE   = done;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// tb_phase_seq_ctrl
// Bench for phase_seq_ctrl. One instance uses the default parameters,
// a second uses a short-green / long-red configuration on two channels.
module tb_phase_seq_ctrl;

  typedef struct packed {
    logic [3:0] req;
    logic       clr;
    logic [3:0] grn;
    logic [3:0] yel;
    logic       ar;
    logic       busy;
    logic [3:0] cnt;
    logic       done;
    logic [3:0] tog;
  } vec_t;

  logic CK;
  logic RN;
  logic RN2;

  int checks;
  int errors;
  logic [3:0] togModel;
  int grantOrder[$];
  int grantLen[$];
  int busyCycles;
  int donePulses;

  vec_t vecs[18];

  phase_seq_ctrl_if #(.NCH(4), .CW(4)) bus ();
  phase_seq_ctrl_if #(.NCH(2), .CW(3)) bus2 ();

  phase_seq_ctrl #(
    .NCH(4), .CW(4), .GREEN_LEN(8), .YEL_LEN(3), .RED_LEN(1)
  ) dut (
    .CK(CK),
    .RN(RN),
    .bus(bus)
  );

  phase_seq_ctrl #(
    .NCH(2), .CW(3), .GREEN_LEN(1), .YEL_LEN(1), .RED_LEN(7)
  ) dut2 (
    .CK(CK),
    .RN(RN2),
    .bus(bus2)
  );

  // Free-running clock, period 10.
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Hard stop in case something never settles.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, update parity model.
  task automatic applyStimulus(input logic [3:0] req, input logic clr);
    bus.REQ = req;
    bus.CLR = clr;
    @(posedge CK);
    #1;
    togModel = clr ? 4'b0 : (togModel ^ req);
  endtask

  // Hold the default instance in reset for two edges, release between edges.
  task automatic doReset();
    RN       = 1'b0;
    bus.REQ  = '0;
    bus.CLR  = 1'b0;
    togModel = '0;
    repeat (2) @(posedge CK);
    #1;
    RN = 1'b1;
  endtask

  // Run cycles with a fixed request pattern, recording grant order,
  // GREEN widths, busy cycles and done pulses; parity checked each cycle.
  task automatic runAndObserve(input logic [3:0] reqHold, input int cycles);
    logic [3:0] prevGrn;
    int runLen;
    int ch;
    grantOrder.delete();
    grantLen.delete();
    busyCycles = 0;
    donePulses = 0;
    runLen     = 0;
    prevGrn    = bus.GRN;
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(reqHold, 1'b0);
      if (bus.GRN != 4'b0 && prevGrn == 4'b0) begin
        ch = -1;
        for (int i = 0; i < 4; i++) if (bus.GRN[i]) ch = i;
        grantOrder.push_back(ch);
        runLen = 0;
      end
      if (bus.GRN != 4'b0) runLen++;
      else if (prevGrn != 4'b0) grantLen.push_back(runLen);
      if (bus.BUSY) busyCycles++;
      if (bus.DONE) donePulses++;
      checkOutput("tog", bus.TOG, togModel);
      prevGrn = bus.GRN;
    end
  endtask

  // Main sequence.
  initial begin
    int expRr[3];
    int expFair[5];
    int bound;
    int g2, y2, r2, max2, d2;
    checks = 0;
    errors = 0;
    RN2 = 1'b0;
    bus2.REQ = '0;
    bus2.CLR = 1'b0;

    // Single request on channel 2, then clear with a request that must be ignored.
    vecs[0]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'b0100};
    vecs[1]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd0, 1'b0, 4'b0100};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0100};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd2, 1'b0, 4'b0100};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd3, 1'b0, 4'b0100};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd4, 1'b0, 4'b0100};
    vecs[6]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd5, 1'b0, 4'b0100};
    vecs[7]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd6, 1'b0, 4'b0100};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'd7, 1'b0, 4'b0100};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'd0, 1'b0, 4'b0100};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0100};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'd2, 1'b0, 4'b0100};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, 4'b0100};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b1, 4'b0100};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'b0100};
    vecs[15] = '{4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'b0000};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'b0000};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 4'b0000};
    expRr   = '{0, 1, 3};
    expFair = '{0, 1, 2, 3, 0};

    $display("[TB] reset state");
    doReset();
    checkOutput("rstGrn", bus.GRN, 4'b0);
    checkOutput("rstYel", bus.YEL, 4'b0);
    checkOutput("rstAllred", bus.ALLRED, 1'b0);
    checkOutput("rstBusy", bus.BUSY, 1'b0);
    checkOutput("rstCnt", bus.CNT, 4'd0);
    checkOutput("rstTog", bus.TOG, 4'b0);
    checkOutput("rstDone", bus.DONE, 1'b0);
    checkOutput("rstPend", dut.pend, 4'b0);
    checkOutput("rstPtr", dut.ptr, 2'd3);

    $display("[TB] single request vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].req, vecs[i].clr);
      checkOutput($sformatf("vec%0d_grn", i), bus.GRN, vecs[i].grn);
      checkOutput($sformatf("vec%0d_yel", i), bus.YEL, vecs[i].yel);
      checkOutput($sformatf("vec%0d_allred", i), bus.ALLRED, vecs[i].ar);
      checkOutput($sformatf("vec%0d_busy", i), bus.BUSY, vecs[i].busy);
      checkOutput($sformatf("vec%0d_cnt", i), bus.CNT, vecs[i].cnt);
      checkOutput($sformatf("vec%0d_done", i), bus.DONE, vecs[i].done);
      checkOutput($sformatf("vec%0d_tog", i), bus.TOG, vecs[i].tog);
    end

    $display("[TB] round robin 1011");
    doReset();
    applyStimulus(4'b1011, 1'b0);
    runAndObserve(4'b0000, 45);
    checkOutput("rrGrants", grantOrder.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("rrOrder%0d", i),
                  (i < grantOrder.size()) ? grantOrder[i] : -1, expRr[i]);
    checkOutput("rrBusy", busyCycles, 36);
    checkOutput("rrDone", donePulses, 3);
    checkOutput("rrPend", dut.pend, 4'b0);

    $display("[TB] set wins on channel 1");
    doReset();
    runAndObserve(4'b0010, 40);
    checkOutput("swGrants", grantOrder.size(), 4);
    for (int i = 0; i < grantOrder.size(); i++)
      checkOutput($sformatf("swOrder%0d", i), grantOrder[i], 1);
    checkOutput("swBusy", busyCycles, 39);
    checkOutput("swPend1", dut.pend[1], 1'b1);

    $display("[TB] fairness 1111");
    doReset();
    runAndObserve(4'b1111, 60);
    checkOutput("fairGrants", grantOrder.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("fairOrder%0d", i),
                  (i < grantOrder.size()) ? grantOrder[i] : -1, expFair[i]);
      checkOutput($sformatf("fairLen%0d", i),
                  (i < grantLen.size()) ? grantLen[i] : -1, 8);
    end

    $display("[TB] synchronous clear mid green");
    doReset();
    bound = 0;
    do begin
      applyStimulus(4'b1111, 1'b0);
      bound++;
    end while (!(bus.GRN != 4'b0 && bus.CNT == 4'd4) && bound < 30);
    checkOutput("clrReach", (bound < 30) ? 1 : 0, 1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("clrGrn", bus.GRN, 4'b0);
    checkOutput("clrYel", bus.YEL, 4'b0);
    checkOutput("clrAllred", bus.ALLRED, 1'b0);
    checkOutput("clrBusy", bus.BUSY, 1'b0);
    checkOutput("clrCnt", bus.CNT, 4'd0);
    checkOutput("clrTog", bus.TOG, 4'b0);
    checkOutput("clrPend", dut.pend, 4'b0);
    runAndObserve(4'b0000, 20);
    checkOutput("clrNoGrant", grantOrder.size(), 0);
    checkOutput("clrIdle", busyCycles, 0);

    $display("[TB] asynchronous reset mid yellow");
    doReset();
    applyStimulus(4'b0100, 1'b0);
    bound = 0;
    do begin
      applyStimulus(4'b0000, 1'b0);
      bound++;
    end while (!(bus.YEL != 4'b0 && bus.CNT == 4'd1) && bound < 30);
    checkOutput("arReach", (bound < 30) ? 1 : 0, 1);
    #2;
    RN = 1'b0;
    #1;
    checkOutput("arYel", bus.YEL, 4'b0);
    checkOutput("arBusy", bus.BUSY, 1'b0);
    checkOutput("arCnt", bus.CNT, 4'd0);
    checkOutput("arTog", bus.TOG, 4'b0);
    RN = 1'b1;

    $display("[TB] parameter sweep instance");
    RN2 = 1'b1;
    bus2.REQ = 2'b01;
    @(posedge CK);
    #1;
    bus2.REQ = 2'b00;
    g2 = 0; y2 = 0; r2 = 0; max2 = 0; d2 = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge CK);
      #1;
      if (bus2.GRN != 2'b0) g2++;
      if (bus2.YEL != 2'b0) y2++;
      if (bus2.ALLRED) r2++;
      if (int'(bus2.CNT) > max2) max2 = int'(bus2.CNT);
      if (bus2.DONE) d2++;
    end
    checkOutput("swpGreen", g2, 1);
    checkOutput("swpYellow", y2, 1);
    checkOutput("swpRed", r2, 7);
    checkOutput("swpCntMax", max2, 6);
    checkOutput("swpDone", d2, 1);
    checkOutput("swpTog", bus2.TOG, 2'b01);
    checkOutput("swpIdle", bus2.BUSY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
